// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_arb_pkg : shared state encodings and port indices            |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package dmem_arb_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] ACK   = 2'd2;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arb2 : two-way combinational round-robin pick                  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt_valid,
  output logic gnt_idx
);

  // On contention the port that did not win last time goes next.
  always_comb begin
    gnt_valid = req0 | req1;
    gnt_idx   = PORT0;
    if (req0 && req1) begin
      gnt_idx = ~last;
    end else if (req1) begin
      gnt_idx = PORT1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_arbiter : round-robin two-port arbiter for the data memory   |
// | Optional grant counters: define DMEM_ARB_STATS_EN. Rev 1.0        |
// +------------------------------------------------------------------+
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
`endif
);

  logic [1:0] state;
  logic       last;
  logic       winner;
  logic       lat_we;
  logic       gnt_valid;
  logic       gnt_idx;

  rr_arb2 u_rr (
    .req0      (req0),
    .req1      (req1),
    .last      (last),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Address/data registers double as the request latch, so they hold
  // between accesses and the memory read path never sees a glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      last            <= PORT1;
      winner          <= PORT0;
      lat_we          <= 1'b0;
      mem_access_addr <= '0;
      mem_write_data  <= '0;
      rdata0          <= '0;
      rdata1          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            winner          <= gnt_idx;
            last            <= gnt_idx;
            lat_we          <= (gnt_idx == PORT1) ? we1 : we0;
            mem_access_addr <= (gnt_idx == PORT1) ? addr1 : addr0;
            mem_write_data  <= (gnt_idx == PORT1) ? wdata1 : wdata0;
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          if (!lat_we) begin
            if (winner == PORT1) rdata1 <= mem_read_data;
            else                 rdata0 <= mem_read_data;
          end
          state <= ACK;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Decoded from state so that reset drops strobes and acks immediately.
  assign mem_write_en = (state == ISSUE) &&  lat_we;
  assign mem_read     = (state == ISSUE) && !lat_we;
  assign ack0         = (state == ACK) && (winner == PORT0);
  assign ack1         = (state == ACK) && (winner == PORT1);

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (state == IDLE && gnt_valid) begin
      if (gnt_idx == PORT0 && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (gnt_idx == PORT1 && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + 1'b1;
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_dmem_arbiter : directed + random bench with transaction model  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_dmem_arbiter;

`ifdef DMEM_ARB_STATS_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif

  logic        clk;
  logic        rst;
  logic        mem_clr;
  logic        req   [2];
  logic        we    [2];
  logic [15:0] addr  [2];
  logic [63:0] wdata [2];
  logic        ack0, ack1, mem_write_en, mem_read;
  logic [63:0] rdata0, rdata1, mem_write_data, mem_read_data;
  logic [15:0] mem_access_addr;
`ifdef DMEM_ARB_STATS_EN
  logic [CW-1:0] grant_cnt0, grant_cnt1;
`endif

  dmem_arbiter #(.ADDR_W(16), .DATA_W(64), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .req0            (req[0]),
    .we0             (we[0]),
    .addr0           (addr[0]),
    .wdata0          (wdata[0]),
    .ack0            (ack0),
    .rdata0          (rdata0),
    .req1            (req[1]),
    .we1             (we[1]),
    .addr1           (addr[1]),
    .wdata1          (wdata[1]),
    .ack1            (ack1),
    .rdata1          (rdata1),
    .mem_access_addr (mem_access_addr),
    .mem_write_data  (mem_write_data),
    .mem_write_en    (mem_write_en),
    .mem_read        (mem_read),
    .mem_read_data   (mem_read_data)
`ifdef DMEM_ARB_STATS_EN
    ,
    .grant_cnt0      (grant_cnt0),
    .grant_cnt1      (grant_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory device: 16 words, decodes the low address bits.
  logic [63:0] mem [16];
  function automatic logic [63:0] init_word(input int i);
    return {32'hA5A5_0000 + 32'(i), 32'h0F0F_0000 + 32'(i)};
  endfunction

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
    end else if (mem_write_en) begin
      mem[mem_access_addr[3:0]] <= mem_write_data;
    end
  end
  assign mem_read_data = mem[mem_access_addr[3:0]];

  // Reference model state (transaction level, times in cycle numbers).
  int          vectors, errors, cyc;
  bit          pend [2];
  int          rep [2];
  int          ack_at [2];
  int          ack_seen [2];
  int          gcnt [2];
  bit          auto_en;
  int          next_free, iss_cyc, ack_cyc;
  bit          last_m, cur_win, cur_we;
  logic [15:0] cur_addr, exp_addr;
  logic [63:0] cur_wdata, cur_rdexp, cur_old, exp_wd;
  logic [63:0] exp_rdata [2];
  logic [63:0] ref_mem [16];
  int          dut_order [$];
  int          dut_ack_cyc [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic start_req(input int p, input bit w, input logic [15:0] a, input logic [63:0] d);
    req[p]   = 1'b1;
    we[p]    = w;
    addr[p]  = a;
    wdata[p] = d;
    pend[p]  = 1'b1;
  endtask

  task automatic model_decide();
    int w;
    if (cyc >= next_free && (req[0] || req[1])) begin
      if (req[0] && req[1]) w = last_m ? 0 : 1;
      else                  w = req[1] ? 1 : 0;
      last_m    = w[0];
      cur_win   = w[0];
      cur_we    = we[w];
      cur_addr  = addr[w];
      cur_wdata = wdata[w];
      cur_old   = ref_mem[addr[w][3:0]];
      cur_rdexp = cur_old;
      if (cur_we) ref_mem[addr[w][3:0]] = wdata[w];
      iss_cyc   = cyc + 1;
      ack_cyc   = cyc + 2;
      next_free = cyc + 3;
      ack_at[w] = cyc + 2;
      gcnt[w]++;
    end
  endtask

  task automatic check_outputs();
    if (cyc == iss_cyc) begin
      exp_addr = cur_addr;
      exp_wd   = cur_wdata;
    end
    if (cyc == ack_cyc && !cur_we) exp_rdata[cur_win] = cur_rdexp;
    chk("mem_write_en", 64'(mem_write_en), 64'(cyc == iss_cyc && cur_we));
    chk("mem_read", 64'(mem_read), 64'(cyc == iss_cyc && !cur_we));
    chk("ack0", 64'(ack0), 64'(cyc == ack_cyc && !cur_win));
    chk("ack1", 64'(ack1), 64'(cyc == ack_cyc && cur_win));
    chk("mem_addr", 64'(mem_access_addr), 64'(exp_addr));
    chk("mem_wdata", mem_write_data, exp_wd);
    chk("rdata0", rdata0, exp_rdata[0]);
    chk("rdata1", rdata1, exp_rdata[1]);
`ifdef DMEM_ARB_STATS_EN
    chk("grant_cnt0", 64'(grant_cnt0), 64'((gcnt[0] > 15) ? 15 : gcnt[0]));
    chk("grant_cnt1", 64'(grant_cnt1), 64'((gcnt[1] > 15) ? 15 : gcnt[1]));
`endif
    if (ack0) begin ack_seen[0] = cyc; dut_order.push_back(0); dut_ack_cyc.push_back(cyc); end
    if (ack1) begin ack_seen[1] = cyc; dut_order.push_back(1); dut_ack_cyc.push_back(cyc); end
  endtask

  task automatic drive_requesters();
    for (int p = 0; p < 2; p++) begin
      if (pend[p] && ack_at[p] == cyc - 1) begin
        pend[p] = 1'b0;
        req[p]  = 1'b0;
        if (rep[p] > 0) begin
          rep[p]--;
          start_req(p, 1'b0, addr[p], {$urandom, $urandom});
        end
      end
      if (auto_en && !pend[p] && $urandom_range(0, 3) != 0)
        start_req(p, 1'($urandom_range(0, 1)), 16'($urandom), {$urandom, $urandom});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
    drive_requesters();
    model_decide();
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 60 && (pend[0] || pend[1] || rep[0] > 0 || rep[1] > 0); i++) step();
    chk(tag, 64'(pend[0] || pend[1]), 64'd0);
  endtask

  task automatic do_req(input int p, input bit w, input logic [15:0] a, input logic [63:0] d);
    start_req(p, w, a, d);
    model_decide();
    wait_done("done");
  endtask

  // Asynchronous reset asserted mid-cycle: outputs must fall with no edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    if (cyc == iss_cyc && cur_we) ref_mem[cur_addr[3:0]] = cur_old;
    chk("rst_mem_write_en", 64'(mem_write_en), 64'd0);
    chk("rst_mem_read", 64'(mem_read), 64'd0);
    chk("rst_ack0", 64'(ack0), 64'd0);
    chk("rst_ack1", 64'(ack1), 64'd0);
    chk("rst_addr", 64'(mem_access_addr), 64'd0);
    chk("rst_wdata", mem_write_data, 64'd0);
    chk("rst_rdata0", rdata0, 64'd0);
    chk("rst_rdata1", rdata1, 64'd0);
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; req[p] = 1'b0; rep[p] = 0; ack_at[p] = -10;
      gcnt[p] = 0; exp_rdata[p] = '0;
    end
    last_m = 1'b1; iss_cyc = -10; ack_cyc = -10;
    exp_addr = '0; exp_wd = '0;
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    next_free = cyc;
  endtask

  int t0;
  logic [63:0] held;

  initial begin
    vectors = 0; errors = 0; cyc = 0; auto_en = 1'b0;
    rst = 1'b0; mem_clr = 1'b1;
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0; we[p] = 1'b0; addr[p] = '0; wdata[p] = '0;
    end
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    @(posedge clk);
    #1;
    do_reset();
    mem_clr = 1'b0;
    repeat (2) step();

    // Port 0 write alone, then port 1 reads it back.
    t0 = cyc;
    do_req(0, 1'b1, 16'h0003, 64'hDEAD_BEEF_0000_0001);
    chk("wr_latency", 64'(ack_seen[0] - t0), 64'd2);
    chk("mem3", mem[3], 64'hDEAD_BEEF_0000_0001);
    do_req(1, 1'b0, 16'h0003, 64'h0);
    chk("rd_rdata1", rdata1, 64'hDEAD_BEEF_0000_0001);
    chk("rd_rdata0_held", rdata0, 64'd0);

    // Hold: port 0 reads, then port 1 writes five times.
    do_req(0, 1'b0, 16'h0007, 64'h0);
    held = rdata0;
    for (int i = 0; i < 5; i++) do_req(1, 1'b1, 16'($urandom), {$urandom, $urandom});
    chk("hold_rdata0", rdata0, held);

    // Reset in the ISSUE cycle of a pending write.
    start_req(0, 1'b1, 16'h0005, 64'h1234_5678_9ABC_DEF0);
    model_decide();
    step();
    do_reset();
    t0 = cyc;
    do_req(0, 1'b0, 16'h0005, 64'h0);
    chk("post_rst_latency", 64'(ack_seen[0] - t0), 64'd2);

`ifdef DMEM_ARB_STATS_EN
    for (int i = 0; i < 20; i++) do_req(0, 1'b0, 16'($urandom), 64'h0);
    chk("cnt0_sat", 64'(grant_cnt0), 64'hF);
    chk("cnt1_zero", 64'(grant_cnt1), 64'd0);
`endif

    // Simultaneous requests straight out of reset, back to back.
    do_reset();
    dut_order.delete();
    dut_ack_cyc.delete();
    rep[0] = 1; rep[1] = 1;
    start_req(0, 1'b0, 16'h0001, 64'h0);
    start_req(1, 1'b0, 16'h0002, 64'h0);
    model_decide();
    wait_done("sim_done");
    chk("sim_n_acks", 64'(dut_order.size()), 64'd4);
    for (int i = 0; i < dut_order.size() && i < 4; i++)
      chk("sim_order", 64'(dut_order[i]), 64'(i % 2));
    for (int i = 1; i < dut_ack_cyc.size(); i++)
      chk("sim_spacing", 64'(dut_ack_cyc[i] - dut_ack_cyc[i-1]), 64'd3);

    // Random traffic from both ports.
    auto_en = 1'b1;
    repeat (1500) step();
    auto_en = 1'b0;
    wait_done("drain");
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
